// File: rtl/seq101_frame_scanner.sv
// seq101_frame_scanner: accepts parallel words over valid/ready, scans them
// MSB-first through a Mealy "101" detector, counts matches across all words of
// a frame (including matches that straddle word boundaries) and reports the
// saturated per-frame count over a valid/ready output handshake.
module seq101_frame_scanner #(
  parameter int W       = 8,
  parameter int CW      = 8,
  parameter bit OVERLAP = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_word,
  input  logic          in_last,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          match_pulse,
  output logic          busy
);

  localparam int BW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
  typedef enum logic [1:0] {S0, S1, S10} det_t;

  state_t        state;
  det_t          det;
  logic          frame_open;
  logic          last_q;
  logic [CW-1:0] match_cnt;
  logic [BW-1:0] bitcnt;
  logic [W-1:0]  sreg;

  logic bit_in;
  logic hit;

  // Current scan bit and whether it completes a "101" match.
  always_comb begin
    bit_in = sreg[W-1];
    hit    = (det == S10) && bit_in;
  end

  // Handshake and status outputs decoded from the registered controller state.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == REPORT);
    out_count = match_cnt;
  end

  // Controller FSM, detector and match counter; reset beats abort beats handshakes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      det         <= S0;
      frame_open  <= 1'b0;
      last_q      <= 1'b0;
      match_cnt   <= '0;
      bitcnt      <= '0;
      sreg        <= '0;
      match_pulse <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      det         <= S0;
      frame_open  <= 1'b0;
      match_cnt   <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sreg   <= in_word;
            bitcnt <= BW'(W - 1);
            last_q <= in_last;
            state  <= SHIFT;
            if (!frame_open) begin
              match_cnt <= '0;
              det       <= S0;
            end
          end
        end
        SHIFT: begin
          match_pulse <= hit;
          if (hit && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CW'(1);
          end
          unique case (det)
            S0:      det <= bit_in ? S1 : S0;
            S1:      det <= bit_in ? S1 : S10;
            S10:     det <= (bit_in && OVERLAP) ? S1 : S0;
            default: det <= S0;
          endcase
          sreg <= {sreg[W-2:0], 1'b0};
          if (bitcnt == '0) begin
            if (last_q) begin
              state <= REPORT;
            end else begin
              state      <= IDLE;
              frame_open <= 1'b1;
            end
          end else begin
            bitcnt <= bitcnt - BW'(1);
          end
        end
        REPORT: begin
          if (out_ready) begin
            state      <= IDLE;
            frame_open <= 1'b0;
            det        <= S0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq101_frame_scanner.sv
// Bench for seq101_frame_scanner: three instances (overlapping, non-overlapping,
// 2-bit saturating counter) share one stimulus stream; expectations come from a
// bit-list model of each frame that searches for "101" occurrences directly.
module tb_seq101_frame_scanner;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST, in_valid, in_last, abort, out_ready;
  logic [W-1:0] in_word;

  logic       in_ready_a, out_valid_a, match_pulse_a, busy_a;
  logic       in_ready_b, out_valid_b, match_pulse_b, busy_b;
  logic       in_ready_c, out_valid_c, match_pulse_c, busy_c;
  logic [7:0] out_count_a, out_count_b;
  logic [1:0] out_count_c;

  seq101_frame_scanner #(.W(W), .CW(8), .OVERLAP(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_word(in_word), .in_last(in_last), .abort(abort),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_count(out_count_a),
    .match_pulse(match_pulse_a), .busy(busy_a));

  seq101_frame_scanner #(.W(W), .CW(8), .OVERLAP(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_word(in_word), .in_last(in_last), .abort(abort),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_count(out_count_b),
    .match_pulse(match_pulse_b), .busy(busy_b));

  seq101_frame_scanner #(.W(W), .CW(2), .OVERLAP(1'b1)) dut_c (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_word(in_word), .in_last(in_last), .abort(abort),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_count(out_count_c),
    .match_pulse(match_pulse_c), .busy(busy_c));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Frame-level reference: the bits seen so far in the open frame.
  int           fb[$];
  int           last_nov;
  int           cnt_ov, cnt_nov;
  bit           pulse_ov, pulse_nov;
  logic [W-1:0] fw[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_clear();
    fb.delete();
    last_nov = -10;
    cnt_ov   = 0;
    cnt_nov  = 0;
  endtask

  // A match ends at the newest bit if the last three bits read 1,0,1; without
  // overlap it must also start after the end of the previous counted match.
  task automatic model_bit(input logic b);
    int n;
    fb.push_back(int'(b));
    n = fb.size();
    pulse_ov  = (n >= 3) && fb[n-3] == 1 && fb[n-2] == 0 && fb[n-1] == 1;
    pulse_nov = pulse_ov && ((n - 3) > last_nov);
    if (pulse_ov)  cnt_ov++;
    if (pulse_nov) begin
      cnt_nov++;
      last_nov = n - 1;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic r, input logic b, input logic v);
    chk({tag, ".ctrl"},
        {23'd0, in_ready_a, in_ready_b, in_ready_c, busy_a, busy_b, busy_c,
         out_valid_a, out_valid_b, out_valid_c},
        {23'd0, {3{r}}, {3{b}}, {3{v}}});
  endtask

  task automatic chk_pulse(input string tag, input logic ov, input logic nov);
    chk({tag, ".pulse"}, {29'd0, match_pulse_a, match_pulse_b, match_pulse_c},
        {29'd0, ov, nov, ov});
  endtask

  task automatic chk_count(input string tag);
    chk({tag, ".count"}, {8'd0, out_count_a, out_count_b, 6'd0, out_count_c},
        {8'd0, 8'(sat(cnt_ov, 255)), 8'(sat(cnt_nov, 255)), 8'(sat(cnt_ov, 3))});
  endtask

  // Offer one word in IDLE, then follow its W shift cycles; abort_k>0 asserts
  // abort before the k-th shift edge.
  task automatic send_word(input logic [W-1:0] w, input logic last, input int abort_k,
                           output bit aborted);
    aborted  = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    abort    = 1'b0;
    step();
    chk_ctrl("accept", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= W; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_word  = W'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      abort    = (k == abort_k);
      step();
      if (k == abort_k) begin
        chk_ctrl("abort_shift", 1'b1, 1'b0, 1'b0);
        chk_pulse("abort_shift", 1'b0, 1'b0);
        model_clear();
        aborted = 1'b1;
        break;
      end
      model_bit(w[W-k]);
      chk_pulse("shift", pulse_ov, pulse_nov);
      if (k < W)      chk_ctrl("shift", 1'b0, 1'b1, 1'b0);
      else if (last) begin
        chk_ctrl("to_report", 1'b0, 1'b1, 1'b1);
        chk_count("to_report");
      end else        chk_ctrl("to_idle", 1'b1, 1'b0, 1'b0);
    end
    abort    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic report(input int stall, input bit abort_rep);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      in_word   = W'($urandom);
      step();
      chk_ctrl("stall", 1'b0, 1'b1, 1'b1);
      chk_count("stall");
      chk_pulse("stall", 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    if (abort_rep) begin
      abort     = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      step();
      chk_ctrl("abort_report", 1'b1, 1'b0, 1'b0);
    end else begin
      out_ready = 1'b1;
      step();
      chk_ctrl("taken", 1'b1, 1'b0, 1'b0);
    end
    chk_pulse("post_report", 1'b0, 1'b0);
    model_clear();
    abort     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input int abort_word, input int abort_k, input int stall,
                           input bit abort_rep, input int maxgap);
    bit ab;
    int g;
    model_clear();
    foreach (fw[i]) begin
      g = (i == 0) ? 0 : $urandom_range(0, maxgap);
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        step();
        chk_ctrl("gap", 1'b1, 1'b0, 1'b0);
        chk_pulse("gap", 1'b0, 1'b0);
      end
      send_word(fw[i], i == fw.size() - 1, (i == abort_word) ? abort_k : 0, ab);
      if (ab) return;
    end
    report(stall, abort_rep);
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_word = '0; in_last = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    model_clear();
    step();
    step();
    RST = 1'b0;
    chk_ctrl("reset", 1'b1, 1'b0, 1'b0);
    chk_pulse("reset", 1'b0, 1'b0);
    chk_count("reset");

    // Single word with overlapping matches.
    fw = '{8'b10101101};
    run_frame(-1, 0, 0, 1'b0, 0);
    // Match straddling a word boundary.
    fw = '{8'b00000010, 8'b10000000};
    run_frame(-1, 0, 0, 1'b0, 2);
    // Consumer stalls for five cycles.
    fw = '{8'b10101101};
    run_frame(-1, 0, 5, 1'b0, 0);
    // Abort on the 4th shift cycle, then a fresh frame.
    fw = '{8'b10101101};
    run_frame(0, 4, 0, 1'b0, 0);
    fw = '{8'b00000101};
    run_frame(-1, 0, 0, 1'b0, 0);

    // Word offered together with abort in IDLE is refused.
    in_valid = 1'b1; in_word = 8'hAD; abort = 1'b1;
    step();
    chk_ctrl("abort_idle", 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0; abort = 1'b0;

    // Saturation of the 2-bit counter.
    fw = '{8'hAA, 8'hAA};
    run_frame(-1, 0, 1, 1'b0, 1);

    // Reset in the middle of a word with in_valid held high.
    in_valid = 1'b1; in_word = 8'hAD; in_last = 1'b1;
    step();
    for (int k = 0; k < 3; k++) step();
    RST = 1'b1;
    step();
    chk_ctrl("rst_mid", 1'b1, 1'b0, 1'b0);
    chk_pulse("rst_mid", 1'b0, 1'b0);
    model_clear();
    chk_count("rst_mid");
    RST = 1'b0; in_valid = 1'b0;
    fw = '{8'b00000101};
    run_frame(-1, 0, 0, 1'b0, 0);

    // Randomized frames with occasional aborts and consumer stalls.
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 3);
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back(W'($urandom));
      run_frame(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1,
                $urandom_range(1, W), $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
